// File: rtl/fp_add_operand_queue.sv
// Operand-pair queue in front of the FP adder: classifies each pair on entry and
// precomputes the IEEE result for special cases, flagged as bypass.
module fp_add_operand_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          MAIN_CLK,
  input  logic          MAIN_RST,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_a,
  input  logic [31:0]   in_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_a,
  output logic [31:0]   out_b,
  output logic          out_bypass,
  output logic [31:0]   out_bypass_val,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [31:0] QNAN       = 32'h7FC0_0000;

  logic [31:0] mem_a   [DEPTH];
  logic [31:0] mem_b   [DEPTH];
  logic [31:0] mem_val [DEPTH];
  logic        mem_byp [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic push;
  logic pop;

  logic a_zero, a_inf, a_nan;
  logic b_zero, b_inf, b_nan;
  logic        byp_c;
  logic [31:0] byp_val_c;

  // Handshake; no same-cycle pass-through when full
  assign in_ready  = (count != FULL_COUNT) & ~MAIN_RST;
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // First-word fall-through from the read pointer
  assign out_a          = mem_a[rd_ptr];
  assign out_b          = mem_b[rd_ptr];
  assign out_bypass     = mem_byp[rd_ptr];
  assign out_bypass_val = mem_val[rd_ptr];

  // Classification; denormals count as zero
  always_comb begin
    a_zero = (in_a[30:23] == 8'h00);
    a_inf  = (in_a[30:23] == 8'hFF) && (in_a[22:0] == 23'd0);
    a_nan  = (in_a[30:23] == 8'hFF) && (in_a[22:0] != 23'd0);
    b_zero = (in_b[30:23] == 8'h00);
    b_inf  = (in_b[30:23] == 8'hFF) && (in_b[22:0] == 23'd0);
    b_nan  = (in_b[30:23] == 8'hFF) && (in_b[22:0] != 23'd0);
  end

  // Special-case result, highest priority first
  always_comb begin
    byp_c     = 1'b0;
    byp_val_c = 32'd0;
    if (a_nan || b_nan) begin
      byp_c     = 1'b1;
      byp_val_c = QNAN;
    end else if (a_inf && b_inf && (in_a[31] != in_b[31])) begin
      byp_c     = 1'b1;
      byp_val_c = QNAN;
    end else if (a_inf) begin
      byp_c     = 1'b1;
      byp_val_c = in_a;
    end else if (b_inf) begin
      byp_c     = 1'b1;
      byp_val_c = in_b;
    end else if (a_zero && b_zero) begin
      byp_c     = 1'b1;
      byp_val_c = {in_a[31] & in_b[31], 31'd0};
    end else if (a_zero) begin
      byp_c     = 1'b1;
      byp_val_c = in_b;
    end else if (b_zero) begin
      byp_c     = 1'b1;
      byp_val_c = in_a;
    end
  end

  // Pointers and occupancy; flush overrides push/pop
  always_ff @(posedge MAIN_CLK or posedge MAIN_RST) begin
    if (MAIN_RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; flush leaves contents in place
  always_ff @(posedge MAIN_CLK or posedge MAIN_RST) begin
    if (MAIN_RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_a[i]   <= 32'd0;
        mem_b[i]   <= 32'd0;
        mem_val[i] <= 32'd0;
        mem_byp[i] <= 1'b0;
      end
    end else if (push && !flush) begin
      mem_a[wr_ptr]   <= in_a;
      mem_b[wr_ptr]   <= in_b;
      mem_val[wr_ptr] <= byp_val_c;
      mem_byp[wr_ptr] <= byp_c;
    end
  end

endmodule
